// File: rtl/led_ctrl_pkg.sv
// ============================================================================
// led_ctrl_pkg : opcodes, mode encodings and helpers for uart_led_ctrl
// Revision     : 1.0
// ============================================================================
`default_nettype none

package led_ctrl_pkg;

  localparam logic [1:0] OP_SET   = 2'b00;
  localparam logic [1:0] OP_BLINK = 2'b01;
  localparam logic [1:0] OP_CHASE = 2'b10;
  localparam logic [1:0] OP_SPEED = 2'b11;

  localparam logic [1:0] MODE_STATIC = 2'd0;
  localparam logic [1:0] MODE_BLINK  = 2'd1;
  localparam logic [1:0] MODE_CHASE  = 2'd2;

  localparam logic [3:0] DEF_SPEED_RST = 4'd4;

  // right=0 rotates toward the MSB (0001 -> 0010), right=1 toward the LSB
  function automatic logic [3:0] rot4(input logic [3:0] v, input logic right);
    return right ? {v[0], v[3:1]} : {v[2:0], v[3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_tick_gen.sv
// ============================================================================
// led_tick_gen : base-tick prescaler plus step counter; step_o pulses once
//                every (speed_i+1)*TICK_DIV cycles after the last clear.
// Revision     : 1.0
// ============================================================================
`default_nettype none

module led_tick_gen #(
  parameter int TICK_DIV = 100000
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       clear_i,
  input  logic [3:0] speed_i,
  output logic       step_o
);

  localparam int             PW          = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]  C_PRESC_TOP = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          tick;
  logic          step;

  always_comb begin
    tick    = (presc_q == C_PRESC_TOP);
    step    = tick && (cnt_q == speed_i);
    presc_d = presc_q + 1'b1;
    cnt_d   = cnt_q;
    if (clear_i) begin
      presc_d = '0;
      cnt_d   = '0;
    end else if (tick) begin
      presc_d = '0;
      cnt_d   = step ? 4'd0 : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      presc_q <= '0;
      cnt_q   <= '0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
    end
  end

  // A clearing command suppresses any step landing in the same cycle
  assign step_o = step && !clear_i;

endmodule

`default_nettype wire

// File: rtl/uart_led_ctrl.sv
// ============================================================================
// uart_led_ctrl : UART command decoder driving static/blink/chase LED patterns.
//                 Define LED_CTRL_ACK_EN to echo accepted commands on the TX port.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module uart_led_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int         TICK_DIV  = 100000,
  parameter logic [3:0] SPEED_RST = DEF_SPEED_RST
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic       ack_drop,
  output logic [1:0] mode,
  output logic [3:0] en
);

  logic [1:0] mode_q, mode_d;
  logic [3:0] en_q, en_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] speed_q, speed_d;
  logic       dir_q, dir_d;
  logic       step;

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .n_reset (n_reset),
    .clear_i (rx_valid),
    .speed_i (speed_q),
    .step_o  (step)
  );

  always_comb begin
    mode_d  = mode_q;
    en_d    = en_q;
    mask_d  = mask_q;
    speed_d = speed_q;
    dir_d   = dir_q;
    if (rx_valid) begin
      case (rx_data[7:6])
        OP_SET: begin
          mode_d = MODE_STATIC;
          en_d   = rx_data[3:0];
        end
        OP_BLINK: begin
          mode_d = MODE_BLINK;
          mask_d = rx_data[3:0];
          en_d   = rx_data[3:0];
        end
        OP_CHASE: begin
          mode_d = MODE_CHASE;
          dir_d  = rx_data[0];
          en_d   = rx_data[0] ? 4'b1000 : 4'b0001;
        end
        default: speed_d = rx_data[3:0];
      endcase
    end else if (step) begin
      case (mode_q)
        // Phase is implied by en: any lit LED means the on phase just ended
        MODE_BLINK: en_d = (en_q != 4'b0000) ? 4'b0000 : mask_q;
        MODE_CHASE: en_d = rot4(en_q, dir_q);
        default:    en_d = en_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      mode_q  <= MODE_STATIC;
      en_q    <= 4'b0000;
      mask_q  <= 4'b0000;
      speed_q <= SPEED_RST;
      dir_q   <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      en_q    <= en_d;
      mask_q  <= mask_d;
      speed_q <= speed_d;
      dir_q   <= dir_d;
    end
  end

  assign mode = mode_q;
  assign en   = en_q;

`ifdef LED_CTRL_ACK_EN
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_data_q, tx_data_d;
  logic       ack_drop_q, ack_drop_d;
  logic       xfer;

  always_comb begin
    xfer       = tx_valid_q && tx_ready;
    tx_valid_d = tx_valid_q && !xfer;
    tx_data_d  = tx_data_q;
    ack_drop_d = 1'b0;
    if (rx_valid) begin
      // The slot frees up in the same cycle on a transfer, so no drop then
      if (!tx_valid_q || xfer) begin
        tx_valid_d = 1'b1;
        tx_data_d  = rx_data;
      end else begin
        ack_drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      tx_valid_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ack_drop_q <= 1'b0;
    end else begin
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      ack_drop_q <= ack_drop_d;
    end
  end

  assign tx_valid = tx_valid_q;
  assign tx_data  = tx_data_q;
  assign ack_drop = ack_drop_q;
`else
  logic unused_ack;
  assign unused_ack = ^{tx_ready, rx_data[5:4]};

  assign tx_valid = 1'b0;
  assign tx_data  = 8'h00;
  assign ack_drop = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_led_ctrl.sv
// ============================================================================
// tb_uart_led_ctrl : directed stimulus with a scoreboard of expected en changes,
//                    TX transfers and ack drops, checked by a negedge monitor.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_uart_led_ctrl;

  logic       clk = 1'b0;
  logic       n_reset = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       tx_ready = 1'b0;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       ack_drop;
  logic [1:0] mode;
  logic [3:0] en;

  uart_led_ctrl #(
    .TICK_DIV  (10),
    .SPEED_RST (4'd4)
  ) dut (
    .clk      (clk),
    .n_reset  (n_reset),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .tx_ready (tx_ready),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .ack_drop (ack_drop),
    .mode     (mode),
    .en       (en)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [3:0] v;
    int         c;
  } en_exp_t;

  en_exp_t    en_q[$];
  logic [7:0] tx_q[$];
  int         drop_q[$];

  int vectors  = 0;
  int miscmp   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscmp++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per observed DUT event
  logic [3:0] prev_en = 4'b0000;
  always @(negedge clk) begin
    if (en !== prev_en) begin
      if (en_q.size() == 0) begin
        chk("en_unexpected_change", {28'd0, en}, {28'd0, prev_en});
      end else begin
        en_exp_t e;
        e = en_q.pop_front();
        chk("en_value", {28'd0, en}, {28'd0, e.v});
        chk("en_cycle", cyc, e.c);
      end
      prev_en = en;
    end
    if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
      if (tx_q.size() == 0) chk("tx_unexpected_xfer", {24'd0, tx_data}, 32'hFFFF_FFFF);
      else chk("tx_xfer_data", {24'd0, tx_data}, {24'd0, tx_q.pop_front()});
    end
    if (ack_drop !== 1'b0) begin
      if (drop_q.size() == 0) chk("drop_unexpected", {31'd0, ack_drop}, 32'd0);
      else chk("drop_cycle", cyc, drop_q.pop_front());
    end
  end

  task automatic send(input logic [7:0] b, output int u);
    rx_valid = 1'b1;
    rx_data  = b;
    u        = cyc + 1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic step_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic exp_en(input logic [3:0] v, input int c);
    en_exp_t e;
    e.v = v;
    e.c = c;
    en_q.push_back(e);
  endtask

  task automatic exp_tx(input logic [7:0] b);
`ifdef LED_CTRL_ACK_EN
    tx_q.push_back(b);
`else
    if (b == 8'hxx) tx_q.push_back(b);
`endif
  endtask

  task automatic exp_drop(input int c);
`ifdef LED_CTRL_ACK_EN
    drop_q.push_back(c);
`else
    if (c < 0) drop_q.push_back(c);
`endif
  endtask

  task automatic chk_ack(input string nm, input logic v, input logic [7:0] d, input logic dr);
`ifdef LED_CTRL_ACK_EN
    chk({nm, "_tx_valid"}, {31'd0, tx_valid}, {31'd0, v});
    chk({nm, "_tx_data"},  {24'd0, tx_data},  {24'd0, d});
    chk({nm, "_ack_drop"}, {31'd0, ack_drop}, {31'd0, dr});
`else
    chk({nm, "_tx_valid"}, {31'd0, tx_valid}, 32'd0 & {31'd0, v});
    chk({nm, "_tx_data"},  {24'd0, tx_data},  32'd0 & {24'd0, d});
    chk({nm, "_ack_drop"}, {31'd0, ack_drop}, 32'd0 & {31'd0, dr});
`endif
  endtask

  initial begin
    int u, u2, u3, u4, u5, a, b, c, d, e;

    #1 n_reset = 1'b0;
    step_cycles(3);
    n_reset = 1'b1;
    step_cycles(2);

    chk("reset_en",   {28'd0, en},   32'd0);
    chk("reset_mode", {30'd0, mode}, 32'd0);
    chk_ack("reset", 1'b0, 8'h00, 1'b0);

    // SET 05 with ack held back, then released for exactly one cycle
    tx_ready = 1'b0;
    send(8'h05, u);
    exp_en(4'b0101, u);
    exp_tx(8'h05);
    chk("set_mode", {30'd0, mode}, 32'd0);
    chk_ack("set_pending", 1'b1, 8'h05, 1'b0);
    step_cycles(4);
    chk_ack("set_held", 1'b1, 8'h05, 1'b0);
    tx_ready = 1'b1;
    step_cycles(1);
    tx_ready = 1'b0;
    chk_ack("set_cleared", 1'b0, 8'h05, 1'b0);

    // Speed 0 blink of 1111: toggles every 10 cycles
    tx_ready = 1'b1;
    send(8'hC0, u);
    exp_tx(8'hC0);
    step_cycles(3);
    chk("speed_keeps_mode", {30'd0, mode}, 32'd0);
    send(8'h4F, u2);
    exp_tx(8'h4F);
    exp_en(4'b1111, u2);
    exp_en(4'b0000, u2 + 10);
    exp_en(4'b1111, u2 + 20);
    exp_en(4'b0000, u2 + 30);
    chk("blink_mode", {30'd0, mode}, 32'd1);
    wait_until(u2 + 34);

    // Speed 1 chase left, then right: one step every 20 cycles
    send(8'hC1, u3);
    exp_tx(8'hC1);
    send(8'h80, u4);
    exp_tx(8'h80);
    exp_en(4'b0001, u4);
    exp_en(4'b0010, u4 + 20);
    exp_en(4'b0100, u4 + 40);
    exp_en(4'b1000, u4 + 60);
    exp_en(4'b0001, u4 + 80);
    chk("chase_mode", {30'd0, mode}, 32'd2);
    wait_until(u4 + 84);
    send(8'h81, u5);
    exp_tx(8'h81);
    exp_en(4'b1000, u5);
    exp_en(4'b0100, u5 + 20);
    exp_en(4'b0010, u5 + 40);
    exp_en(4'b0001, u5 + 60);
    wait_until(u5 + 64);

    // Back-to-back commands while the ack is stalled: second ack dropped
    tx_ready = 1'b0;
    send(8'h05, a);
    exp_tx(8'h05);
    exp_en(4'b0101, a);
    send(8'h0A, b);
    exp_en(4'b1010, b);
    exp_drop(b);
    chk_ack("drop_pulse", 1'b1, 8'h05, 1'b1);
    step_cycles(3);
    chk_ack("drop_kept", 1'b1, 8'h05, 1'b0);
    chk("drop_en", {28'd0, en}, 32'hA);

    // Command coinciding with a transfer reloads the ack slot without a drop
    tx_ready = 1'b1;
    send(8'h03, c);
    exp_tx(8'h03);
    exp_en(4'b0011, c);
    chk_ack("xfer_reload", 1'b1, 8'h03, 1'b0);
    step_cycles(1);
    chk_ack("xfer_done", 1'b0, 8'h03, 1'b0);

    // Asynchronous reset mid-blink, then default speed 4 gives 50-cycle steps
    send(8'h4F, d);
    exp_tx(8'h4F);
    exp_en(4'b1111, d);
    wait_until(d + 10);
    n_reset = 1'b0;
    exp_en(4'b0000, cyc);
    #1;
    chk("async_rst_en",   {28'd0, en},   32'd0);
    chk("async_rst_mode", {30'd0, mode}, 32'd0);
    chk_ack("async_rst", 1'b0, 8'h00, 1'b0);
    step_cycles(3);
    n_reset = 1'b1;
    step_cycles(1);
    send(8'h4F, e);
    exp_tx(8'h4F);
    exp_en(4'b1111, e);
    exp_en(4'b0000, e + 50);
    exp_en(4'b1111, e + 100);
    wait_until(e + 104);

    chk("en_events_left",   en_q.size(),   32'd0);
    chk("tx_events_left",   tx_q.size(),   32'd0);
    chk("drop_events_left", drop_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation exceeded time limit at cycle %0d", cyc);
    miscmp++;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscmp);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/uart_led_ctrl.md
# uart_led_ctrl

Command sequencer between the UART receiver and the 4-bit LED driver. It decodes single-byte commands from the UART RX strobe and drives the LED driver's `en[3:0]` input with static, blink or chase patterns, paced by a prescaled tick. When acknowledge is compiled in, it also echoes each accepted command byte to the UART TX through a valid/ready handshake.

## Interface
- `TICK_DIV`, default 100000: clk cycles per base tick (100 ms at 1 MHz); must be ≥ 2.
- `SPEED_RST`, default 4: reset value of the 4-bit speed field; step period is (speed+1) base ticks.
- `clk` in 1: system clock, 1 MHz.
- `n_reset` in 1: reset. Asynchronous assert, active-low.
- `rx_valid` in 1: one-cycle strobe; `rx_data` is a received byte.
- `rx_data` in 8: command byte.
- `tx_ready` in 1: UART TX can accept a byte this cycle.
- `tx_valid` out 1: ack byte pending.
- `tx_data` out 8: ack byte.
- `ack_drop` out 1: one-cycle pulse when an ack is discarded.
- `mode` out 2: current mode (0 STATIC, 1 BLINK, 2 CHASE).
- `en` out 4: pattern to the LED driver; active-high, so 1 lights the LED.

## Operation
- Command decode uses `rx_data[7:6]`:
  - 00 SET: mode STATIC; `en` = `rx_data[3:0]`.
  - 01 BLINK: mode BLINK; mask = `rx_data[3:0]`; `en` = mask (on phase).
  - 10 CHASE: mode CHASE; dir = `rx_data[0]`; `en` = 0001 if dir=0 (rotate left), 1000 if dir=1 (rotate right).
  - 11 SPEED: speed = `rx_data[3:0]`; mode and `en` are unchanged.
- Every command clears the prescaler and the step counter.
- Step generation:
  - Prescaler counts 0..TICK_DIV-1; tick fires at the terminal count.
  - Step counter counts ticks 0..speed; a step fires on a tick when the counter equals speed, then the counter clears.
- Behaviour on each step:
  - STATIC: no change.
  - BLINK: `en` alternates between mask and 0000.
  - CHASE: `en` rotates one bit in the direction set by dir, wrapping 1000↔0001.
- BLINK with mask 0000 is legal: `en` stays 0.
- A command and a step in the same cycle: the command wins and the step is discarded.
- Ack (with macro):
  - Every command loads `tx_data` = `rx_data` and sets `tx_valid`.
  - A transfer occurs when `tx_valid && tx_ready`; `tx_valid` then clears the next cycle.
  - `tx_data` is stable while `tx_valid` is high.
  - If `rx_valid` arrives while an ack is pending and no transfer happens that cycle: the command still executes, the new ack is dropped, `ack_drop` pulses, and the pending ack is kept.
  - If `rx_valid` coincides with a transfer: the new ack loads and `tx_valid` stays 1. No drop.
- Reset values: `en`=0000, `mode`=STATIC, speed=SPEED_RST, mask=0000, dir=0, counters=0, `tx_valid`=0, `tx_data`=00, `ack_drop`=0.

## Timing
- Command to `en`/`mode`/`tx_valid` update: one cycle after the `rx_valid` cycle (registered).
- First step occurs exactly (speed+1)×TICK_DIV cycles after the command's update cycle; later steps follow at that same period.
- `en` changes on the clock edge after the step condition; all outputs are registered.
- Asserting `n_reset` mid-operation forces reset values immediately, with no clock needed; after deassertion, operation resumes from STATIC/`en`=0.

## Configuration
- `LED_CTRL_ACK_EN` defined: ack path is present as described above.
- Undefined:
  - `tx_valid`, `tx_data` and `ack_drop` are tied to 0.
  - `tx_ready` is ignored.
  - The port list is unchanged; pattern behaviour is identical.

## Structure
- Package `led_ctrl_pkg` holds:
  - opcode constants OP_SET/OP_BLINK/OP_CHASE/OP_SPEED;
  - mode encodings MODE_STATIC/MODE_BLINK/MODE_CHASE;
  - default SPEED_RST.
- Sub-module `led_tick_gen` contains the prescaler plus step counter.
  - Inputs: clear, speed.
  - Output: one-cycle step pulse.
- Top level contains the command decode, pattern registers and ack register.

## Test plan
Bench uses TICK_DIV=10 and the macro defined.
- Reset release -> `en`=0000, `mode`=0, `tx_valid`=0. Then `rx_data`=05 -> next cycle `en`=0101, `tx_valid`=1, `tx_data`=05, held until `tx_ready`=1, cleared the cycle after.
- C0 (speed 0) then 4F -> `en`=1111, toggling 0000/1111 every 10 cycles.
- C1 then 80 -> `en` steps 0001, 0010, 0100, 1000, 0001 every 20 cycles. Repeat with 81 -> 1000, 0100, 0010, 0001.
- `tx_ready`=0 held; send 05 then 0A -> `en`=1010, `tx_data` stays 05, `ack_drop` pulses once.
- `tx_valid`=1 with `tx_ready`=1 in the same cycle as `rx_valid` with 03 -> `tx_data`=03, `tx_valid` stays 1, no `ack_drop`.
- During BLINK (mask 1111), assert `n_reset` mid-period -> `en`=0000 at once; after release, send 4F and observe a 50-cycle period (SPEED_RST=4).
